rx_tcp_csum_output_ctrl: RTL and testbench

- Sits on the RX path directly after the TCP checksum engine and consumes its response side.
- Strips the 12-byte pseudo-header from the first beat and captures the 20-byte base TCP header.
- Streams the remaining bytes (options plus payload) downstream.
- After the stream ends and the checksum result arrives, emits one header record carrying a pass/fail flag; downstream commits or drops the payload.

---
 rtl/rx_tcp_csum_output_ctrl_if.sv | 45 ++++
 rtl/rx_tcp_csum_output_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rx_tcp_csum_output_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_tcp_csum_output_ctrl_if.sv
// Bus between the TCP checksum engine response side and the downstream header/payload consumers.
// master is the controller's view; slave is the view of the logic around it.
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif

interface rx_tcp_csum_output_ctrl_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0]        resp_tdata;
  logic [KEEP_WIDTH-1:0]        resp_tkeep;
  logic                         resp_tval;
  logic                         resp_trdy;
  logic                         resp_tlast;
  logic                         resp_csum_val;
  logic [15:0]                  resp_csum;
  logic                         resp_csum_rdy;
  logic                         dst_hdr_val;
  logic                         dst_hdr_rdy;
  logic [31:0]                  dst_src_ip;
  logic [31:0]                  dst_dst_ip;
  logic [159:0]                 dst_tcp_hdr;
  logic [15:0]                  dst_payload_len;
  logic                         dst_csum_ok;
  logic                         dst_data_val;
  logic [DATA_WIDTH-1:0]        dst_data;
  logic                         dst_data_rdy;
  logic                         dst_data_last;
  logic [`MAC_PADBYTES_W-1:0]   dst_data_padbytes;

  modport master (
    input  resp_tdata, resp_tkeep, resp_tval, resp_tlast, resp_csum_val, resp_csum,
           dst_hdr_rdy, dst_data_rdy,
    output resp_trdy, resp_csum_rdy, dst_hdr_val, dst_src_ip, dst_dst_ip, dst_tcp_hdr,
           dst_payload_len, dst_csum_ok, dst_data_val, dst_data, dst_data_last, dst_data_padbytes
  );

  modport slave (
    output resp_tdata, resp_tkeep, resp_tval, resp_tlast, resp_csum_val, resp_csum,
           dst_hdr_rdy, dst_data_rdy,
    input  resp_trdy, resp_csum_rdy, dst_hdr_val, dst_src_ip, dst_dst_ip, dst_tcp_hdr,
           dst_payload_len, dst_csum_ok, dst_data_val, dst_data, dst_data_last, dst_data_padbytes
  );
endinterface

// File: rtl/rx_tcp_csum_output_ctrl.sv
// Strips the pseudo-header from beat 0, forwards options/payload, then emits a header record with pass/fail.
// Define RX_TCP_LEN_CHECK_EN to also require the forwarded byte count to match the pseudo-header length.
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif

module rx_tcp_csum_output_ctrl #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  rx_tcp_csum_output_ctrl_if.master bus
);
  localparam int PW = `MAC_PADBYTES_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_PAYLOAD   = 2'd1;
  localparam logic [1:0] S_WAIT_CSUM = 2'd2;
  localparam logic [1:0] S_HDR_OUT   = 2'd3;

  localparam logic [15:0] TCP_HDR_LEN = 16'd20;

  // Invalid bytes sit at the LSB end, so the pad count is the index of the lowest set keep bit.
  function automatic logic [PW-1:0] pad_count(input logic [KEEP_WIDTH-1:0] keep);
    logic [PW-1:0] n;
    n = PW'(KEEP_WIDTH);
    for (int i = KEEP_WIDTH - 1; i >= 0; i--)
      if (keep[i]) n = PW'(i);
    return n;
  endfunction

  function automatic logic [15:0] sat_payload_len(input logic [15:0] len);
    return (len < TCP_HDR_LEN) ? 16'd0 : len - TCP_HDR_LEN;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [31:0]   src_ip_q, src_ip_d;
  logic [31:0]   dst_ip_q, dst_ip_d;
  logic [159:0]  tcp_hdr_q, tcp_hdr_d;
  logic [15:0]   tcp_len_q, tcp_len_d;
  logic          runt_q, runt_d;
  logic          csum_vld_q, csum_vld_d;
  logic [15:0]   csum_q, csum_d;

  logic          resp_trdy, resp_csum_rdy, dst_data_val, dst_hdr_val;
  logic          data_hs, csum_hs, len_ok;
  logic [PW-1:0] padbytes;

  assign padbytes = pad_count(bus.resp_tkeep);

  always_comb begin
    resp_trdy     = 1'b0;
    resp_csum_rdy = 1'b0;
    dst_data_val  = 1'b0;
    dst_hdr_val   = 1'b0;
    case (state_q)
      S_IDLE:      resp_trdy = 1'b1;
      S_PAYLOAD: begin
        resp_trdy     = bus.dst_data_rdy;
        dst_data_val  = bus.resp_tval;
        resp_csum_rdy = !csum_vld_q;
      end
      S_WAIT_CSUM: resp_csum_rdy = !csum_vld_q;
      S_HDR_OUT:   dst_hdr_val = 1'b1;
      default: ;
    endcase
  end

  assign data_hs = bus.resp_tval && resp_trdy;
  assign csum_hs = bus.resp_csum_val && resp_csum_rdy;

  always_comb begin
    state_d    = state_q;
    src_ip_d   = src_ip_q;
    dst_ip_d   = dst_ip_q;
    tcp_hdr_d  = tcp_hdr_q;
    tcp_len_d  = tcp_len_q;
    runt_d     = runt_q;
    csum_vld_d = csum_vld_q;
    csum_d     = csum_q;

    if (csum_hs) begin
      csum_vld_d = 1'b1;
      csum_d     = bus.resp_csum;
    end

    case (state_q)
      S_IDLE: begin
        if (data_hs) begin
          src_ip_d  = bus.resp_tdata[DATA_WIDTH-1 -: 32];
          dst_ip_d  = bus.resp_tdata[DATA_WIDTH-33 -: 32];
          tcp_len_d = bus.resp_tdata[175:160];
          tcp_hdr_d = bus.resp_tdata[159:0];
          runt_d    = bus.resp_tlast && !(&bus.resp_tkeep);
          state_d   = bus.resp_tlast ? S_WAIT_CSUM : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (data_hs && bus.resp_tlast) state_d = S_WAIT_CSUM;
      end
      S_WAIT_CSUM: begin
        if (csum_vld_q || csum_hs) state_d = S_HDR_OUT;
      end
      S_HDR_OUT: begin
        if (bus.dst_hdr_rdy) begin
          csum_vld_d = 1'b0;
          runt_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      tcp_hdr_q  <= '0;
      tcp_len_q  <= '0;
      runt_q     <= 1'b0;
      csum_vld_q <= 1'b0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_ip_q   <= src_ip_d;
      dst_ip_q   <= dst_ip_d;
      tcp_hdr_q  <= tcp_hdr_d;
      tcp_len_q  <= tcp_len_d;
      runt_q     <= runt_d;
      csum_vld_q <= csum_vld_d;
      csum_q     <= csum_d;
    end
  end

`ifdef RX_TCP_LEN_CHECK_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (state_q == S_IDLE)
      byte_cnt_d = '0;
    else if (state_q == S_PAYLOAD && data_hs)
      byte_cnt_d = byte_cnt_q + (16'(KEEP_WIDTH) - 16'(padbytes));
  end

  always_ff @(posedge clk) begin
    if (rst) byte_cnt_q <= '0;
    else     byte_cnt_q <= byte_cnt_d;
  end

  assign len_ok = (byte_cnt_q + TCP_HDR_LEN) == tcp_len_q;
`else
  assign len_ok = 1'b1;
`endif

  assign bus.resp_trdy         = resp_trdy;
  assign bus.resp_csum_rdy     = resp_csum_rdy;
  assign bus.dst_hdr_val       = dst_hdr_val;
  assign bus.dst_src_ip        = src_ip_q;
  assign bus.dst_dst_ip        = dst_ip_q;
  assign bus.dst_tcp_hdr       = tcp_hdr_q;
  assign bus.dst_payload_len   = sat_payload_len(tcp_len_q);
  assign bus.dst_csum_ok       = (csum_q == 16'h0000) && !runt_q && len_ok;
  assign bus.dst_data_val      = dst_data_val;
  assign bus.dst_data          = bus.resp_tdata;
  assign bus.dst_data_last     = bus.resp_tlast;
  assign bus.dst_data_padbytes = padbytes;
endmodule

// File: tb/tb_rx_tcp_csum_output_ctrl.sv
// Directed bench for rx_tcp_csum_output_ctrl: segments are driven through the interface and the
// header record and forwarded payload are compared against hand-computed values.
module tb_rx_tcp_csum_output_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tog_en = 1'b0;

  always #5 clk = ~clk;

  rx_tcp_csum_output_ctrl_if #(.DATA_WIDTH(256)) bus ();

  rx_tcp_csum_output_ctrl #(.DATA_WIDTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef RX_TCP_LEN_CHECK_EN
  localparam logic LEN_CHK = 1'b1;
`else
  localparam logic LEN_CHK = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Payload beats seen downstream, in order of handshake.
  logic [255:0] got_data[$];
  logic         got_last[$];
  int           got_pad[$];

  always @(negedge clk) begin
    if (!rst && bus.dst_data_val && bus.dst_data_rdy) begin
      got_data.push_back(bus.dst_data);
      got_last.push_back(bus.dst_data_last);
      got_pad.push_back(int'(bus.dst_data_padbytes));
    end
  end

  initial begin
    bus.dst_data_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.dst_data_rdy = tog_en ? ~bus.dst_data_rdy : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [255:0] mk_beat0(input logic [31:0] src, input logic [31:0] dst,
                                            input logic [15:0] len, input logic [159:0] hdr);
    return {src, dst, 8'h00, 8'h06, len, hdr};
  endfunction

  function automatic logic [255:0] pat(input int i);
    return {8{32'hD00D_0000 + 32'(i)}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge; returns one time unit after the accepting edge.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
    int w = 0;
    bus.resp_tdata = d;
    bus.resp_tkeep = k;
    bus.resp_tlast = l;
    bus.resp_tval  = 1'b1;
    #1;
    while (!bus.resp_trdy && w < 200) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (w >= 200) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.resp_tval = 1'b0;
  endtask

  task automatic send_csum(input logic [15:0] c);
    int w = 0;
    bus.resp_csum     = c;
    bus.resp_csum_val = 1'b1;
    #1;
    while (!bus.resp_csum_rdy && w < 200) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (w >= 200) check("csum_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.resp_csum_val = 1'b0;
  endtask

  task automatic send_seg(input logic [255:0] b0, input int n_pay, input logic [31:0] last_keep,
                          input int seed);
    send_beat(b0, (n_pay == 0) ? last_keep : 32'hFFFF_FFFF, n_pay == 0);
    for (int i = 0; i < n_pay; i++)
      send_beat(pat(seed + i), (i == n_pay - 1) ? last_keep : 32'hFFFF_FFFF, i == n_pay - 1);
  endtask

  task automatic wait_hdr(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!bus.dst_hdr_val && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) check("hdr_timeout", 0, 1);
  endtask

  task automatic take_hdr();
    step();
    bus.dst_hdr_rdy = 1'b1;
    step();
    bus.dst_hdr_rdy = 1'b0;
  endtask

  task automatic check_hdr(input string tag, input logic [31:0] src, input logic [31:0] dst,
                           input logic [159:0] hdr, input logic [15:0] plen, input logic ok);
    check({tag, "_hdr_val"}, bus.dst_hdr_val, 1'b1);
    check({tag, "_src_ip"}, bus.dst_src_ip, src);
    check({tag, "_dst_ip"}, bus.dst_dst_ip, dst);
    check({tag, "_tcp_hdr"}, bus.dst_tcp_hdr, hdr);
    check({tag, "_payload_len"}, bus.dst_payload_len, plen);
    check({tag, "_csum_ok"}, bus.dst_csum_ok, ok);
  endtask

  task automatic check_payload(input string tag, input int base, input int n_pay, input int last_pad,
                               input int seed);
    check({tag, "_beats"}, got_data.size() - base, n_pay);
    for (int i = 0; i < n_pay && base + i < got_data.size(); i++) begin
      check({tag, "_data"}, got_data[base + i], pat(seed + i));
      check({tag, "_last"}, got_last[base + i], i == n_pay - 1);
      check({tag, "_pad"}, got_pad[base + i], (i == n_pay - 1) ? last_pad : 0);
    end
  endtask

  localparam logic [31:0]  IP_A  = 32'hC0A8_0001;
  localparam logic [31:0]  IP_B  = 32'h0A00_0002;
  localparam logic [159:0] HDR_A = 160'h1F90_C350_0000_1000_0000_2000_5018_FFFF_0000_0000;
  localparam logic [159:0] HDR_B = 160'h0050_ABCD_1234_5678_9ABC_DEF0_5010_0400_0000_0000;

  initial begin
    int base;
    int cyc;
    logic seg_done;

    bus.resp_tdata    = '0;
    bus.resp_tkeep    = '0;
    bus.resp_tval     = 1'b0;
    bus.resp_tlast    = 1'b0;
    bus.resp_csum_val = 1'b0;
    bus.resp_csum     = '0;
    bus.dst_hdr_rdy   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_trdy", bus.resp_trdy, 1'b1);
    check("rst_hdr_val", bus.dst_hdr_val, 1'b0);
    check("rst_data_val", bus.dst_data_val, 1'b0);
    check("rst_csum_rdy", bus.resp_csum_rdy, 1'b0);
    check("rst_payload_len", bus.dst_payload_len, 16'd0);
    step();

    // Header-only segment: no payload beats, record one cycle after the checksum handshake.
    base = got_data.size();
    send_seg(mk_beat0(IP_A, IP_B, 16'd20, HDR_A), 0, 32'hFFFF_FFFF, 0);
    check("hdronly_csum_rdy", bus.resp_csum_rdy, 1'b1);
    send_csum(16'h0000);
    wait_hdr(cyc);
    check("hdronly_latency", cyc, 0);
    check_hdr("hdronly", IP_A, IP_B, HDR_A, 16'd0, 1'b1);
    check("hdronly_beats", got_data.size() - base, 0);
    take_hdr();

    // Length 84: two full payload beats.
    base = got_data.size();
    send_seg(mk_beat0(IP_B, IP_A, 16'd84, HDR_B), 2, 32'hFFFF_FFFF, 10);
    send_csum(16'h0000);
    wait_hdr(cyc);
    check_hdr("len84", IP_B, IP_A, HDR_B, 16'd64, 1'b1);
    check_payload("len84", base, 2, 0, 10);
    take_hdr();

    // Length 64: full beat plus 12-byte tail, 20 pad bytes.
    base = got_data.size();
    send_seg(mk_beat0(IP_A, IP_B, 16'd64, HDR_A), 2, 32'hFFF0_0000, 20);
    send_csum(16'h0000);
    wait_hdr(cyc);
    check_hdr("len64", IP_A, IP_B, HDR_A, 16'd44, 1'b1);
    check_payload("len64", base, 2, 20, 20);
    take_hdr();

    // Bad checksum: payload still forwarded in full.
    base = got_data.size();
    send_seg(mk_beat0(IP_B, IP_A, 16'd84, HDR_B), 2, 32'hFFFF_FFFF, 30);
    send_csum(16'h1234);
    wait_hdr(cyc);
    check_hdr("badcsum", IP_B, IP_A, HDR_B, 16'd64, 1'b0);
    check_payload("badcsum", base, 2, 0, 30);
    take_hdr();

    // Checksum alongside the last payload beat, then backpressured header.
    base = got_data.size();
    send_beat(mk_beat0(IP_A, IP_B, 16'd84, HDR_B), 32'hFFFF_FFFF, 1'b0);
    send_beat(pat(40), 32'hFFFF_FFFF, 1'b0);
    fork
      send_beat(pat(41), 32'hFFFF_FFFF, 1'b1);
      send_csum(16'h0000);
    join
    wait_hdr(cyc);
    for (int i = 0; i < 5; i++) begin
      check_hdr("hold", IP_A, IP_B, HDR_B, 16'd64, 1'b1);
      check("hold_trdy", bus.resp_trdy, 1'b0);
      @(negedge clk);
    end
    check_payload("hold", base, 2, 0, 40);
    take_hdr();

    // Runt: beat 0 alone with a partial keep.
    send_seg(mk_beat0(IP_B, IP_B, 16'd20, HDR_A), 0, 32'hFFFF_FF00, 0);
    send_csum(16'h0000);
    wait_hdr(cyc);
    check_hdr("runt", IP_B, IP_B, HDR_A, 16'd0, 1'b0);
    take_hdr();

    // Downstream ready toggling every cycle: four beats, 12-byte tail.
    base = got_data.size();
    seg_done = 1'b0;
    tog_en = 1'b1;
    fork
      begin
        send_seg(mk_beat0(IP_A, IP_B, 16'd128, HDR_A), 4, 32'hFFF0_0000, 50);
        seg_done = 1'b1;
      end
      begin
        while (!seg_done) begin
          @(negedge clk);
          if (bus.dst_data_val) check("toggle_trdy_mirror", bus.resp_trdy, bus.dst_data_rdy);
        end
      end
    join
    tog_en = 1'b0;
    send_csum(16'h0000);
    wait_hdr(cyc);
    check_hdr("toggle", IP_A, IP_B, HDR_A, 16'd108, 1'b1);
    check_payload("toggle", base, 4, 20, 50);
    take_hdr();

    // Reset in the middle of a payload stream, then a fresh segment.
    send_beat(mk_beat0(IP_B, IP_A, 16'd84, HDR_B), 32'hFFFF_FFFF, 1'b0);
    send_beat(pat(60), 32'hFFFF_FFFF, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_trdy", bus.resp_trdy, 1'b1);
    check("midrst_data_val", bus.dst_data_val, 1'b0);
    check("midrst_hdr_val", bus.dst_hdr_val, 1'b0);
    check("midrst_csum_rdy", bus.resp_csum_rdy, 1'b0);
    check("midrst_src_ip", bus.dst_src_ip, 32'd0);
    check("midrst_tcp_hdr", bus.dst_tcp_hdr, 160'd0);
    step();
    base = got_data.size();
    send_seg(mk_beat0(IP_A, IP_A, 16'd84, HDR_A), 2, 32'hFFFF_FFFF, 70);
    send_csum(16'h0000);
    wait_hdr(cyc);
    check_hdr("postrst", IP_A, IP_A, HDR_A, 16'd64, 1'b1);
    check_payload("postrst", base, 2, 0, 70);
    take_hdr();

    // Length below 20 saturates to zero.
    send_seg(mk_beat0(IP_B, IP_A, 16'd8, HDR_B), 0, 32'hFFFF_FFFF, 0);
    send_csum(16'h0000);
    wait_hdr(cyc);
    check_hdr("short_len", IP_B, IP_A, HDR_B, 16'd0, !LEN_CHK);
    take_hdr();

    // Length 84 but only 40 payload bytes sent.
    base = got_data.size();
    send_seg(mk_beat0(IP_A, IP_B, 16'd84, HDR_B), 2, 32'hFF00_0000, 80);
    send_csum(16'h0000);
    wait_hdr(cyc);
    check_hdr("lenmis", IP_A, IP_B, HDR_B, 16'd64, !LEN_CHK);
    check_payload("lenmis", base, 2, 24, 80);
    take_hdr();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
